// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : present_pkg
//  Description : Shared types, widths and helper functions for PRESENT-80
//                decryption (FSM state, forward S-box, inverse bit layer).
//  Revision    : 1.0 - initial release
// ============================================================================
package present_pkg;

    localparam int PRESENT_ROUNDS = 31;
    localparam int KEY_W          = 80;
    localparam int BLOCK_W        = 64;
    localparam int RC_W           = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        DEC    = 2'd2
    } state_t;

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Forward layer moves bit i to 16*i mod 63; this pulls it back.
    function automatic logic [BLOCK_W-1:0] inv_perm(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        for (int i = 0; i < 63; i++) begin
            y[i] = x[(16 * i) % 63];
        end
        y[63] = x[63];
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/present_inv_sbox4.sv
`default_nettype none
// ============================================================================
//  Module      : present_inv_sbox4
//  Description : 4-bit PRESENT inverse S-box cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module present_inv_sbox4 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    always_comb begin
        o_nib = 4'h0;
        case (i_nib)
            4'h0: o_nib = 4'h5;  4'h1: o_nib = 4'hE;  4'h2: o_nib = 4'hF;  4'h3: o_nib = 4'h8;
            4'h4: o_nib = 4'hC;  4'h5: o_nib = 4'h1;  4'h6: o_nib = 4'h2;  4'h7: o_nib = 4'hD;
            4'h8: o_nib = 4'hB;  4'h9: o_nib = 4'h4;  4'hA: o_nib = 4'h6;  4'hB: o_nib = 4'h3;
            4'hC: o_nib = 4'h0;  4'hD: o_nib = 4'h7;  4'hE: o_nib = 4'h9;  default: o_nib = 4'hA;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/present_inv_sbox_layer.sv
`default_nettype none
// ============================================================================
//  Module      : present_inv_sbox_layer
//  Description : 64-bit inverse substitution layer, 16 parallel nibble cells.
//  Revision    : 1.0 - initial release
// ============================================================================
module present_inv_sbox_layer (
    input  logic [63:0] i_data,
    output logic [63:0] o_data
);

    for (genvar g = 0; g < 16; g++) begin : g_nib
        present_inv_sbox4 u_cell (
            .i_nib (i_data[4*g +: 4]),
            .o_nib (o_data[4*g +: 4])
        );
    end

endmodule
`default_nettype wire

// File: rtl/present_dec_core.sv
`default_nettype none
// ============================================================================
//  Module      : present_dec_core
//  Description : Iterative PRESENT-80 decryption, one round per clock.
//                Optional K32 key cache: PRESENT_DEC_KEYCACHE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module present_dec_core
    import present_pkg::*;
#(
    parameter int ROUNDS = PRESENT_ROUNDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [KEY_W-1:0]   key,
    input  logic [BLOCK_W-1:0] data_in,
`ifdef PRESENT_DEC_KEYCACHE_EN
    input  logic               key_reuse,
`endif
    output logic               busy,
    output logic               done,
    output logic [BLOCK_W-1:0] data_out
);

    localparam logic [RC_W-1:0] c_last_rc = RC_W'(ROUNDS);

    state_t             r_state, w_state_nxt;
    logic [RC_W-1:0]    r_rc, w_rc_nxt;
    logic [KEY_W-1:0]   r_key, w_key_nxt;
    logic [KEY_W-1:0]   w_key_rot, w_key_fwd, w_key_xor, w_key_isb, w_key_inv;
    logic [3:0]         w_key_nib_inv;
    logic [BLOCK_W-1:0] r_blk, w_blk_nxt, w_blk_perm, w_blk_isb, w_blk_dec;
    logic [BLOCK_W-1:0] r_dout, w_dout_nxt;
    logic               r_done, w_done_nxt;
    logic               w_reuse;
    logic [KEY_W-1:0]   w_cache_key;

    // Forward schedule step used during key expansion.
    assign w_key_rot = {r_key[18:0], r_key[79:19]};
    assign w_key_fwd = {sbox_fwd(w_key_rot[79:76]), w_key_rot[75:20],
                        w_key_rot[19:15] ^ r_rc, w_key_rot[14:0]};

    // Inverse schedule step: undo the counter XOR, the S-box, then the rotation.
    assign w_key_xor = {r_key[79:20], r_key[19:15] ^ r_rc, r_key[14:0]};
    present_inv_sbox4 u_key_isbox (
        .i_nib (w_key_xor[79:76]),
        .o_nib (w_key_nib_inv)
    );
    assign w_key_isb = {w_key_nib_inv, w_key_xor[75:0]};
    assign w_key_inv = {w_key_isb[60:0], w_key_isb[79:61]};

    assign w_blk_perm = inv_perm(r_blk);
    present_inv_sbox_layer u_blk_isbox (
        .i_data (w_blk_perm),
        .o_data (w_blk_isb)
    );
    assign w_blk_dec = w_blk_isb ^ w_key_inv[79:16];

`ifdef PRESENT_DEC_KEYCACHE_EN
    logic [KEY_W-1:0] r_cache;
    logic             r_cache_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache     <= '0;
            r_cache_vld <= 1'b0;
        end else if (r_state == KEYEXP && r_rc == c_last_rc) begin
            r_cache     <= w_key_fwd;
            r_cache_vld <= 1'b1;
        end
    end

    assign w_reuse     = key_reuse & r_cache_vld;
    assign w_cache_key = r_cache;
`else
    assign w_reuse     = 1'b0;
    assign w_cache_key = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rc    <= '0;
            r_key   <= '0;
            r_blk   <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rc    <= w_rc_nxt;
            r_key   <= w_key_nxt;
            r_blk   <= w_blk_nxt;
            r_dout  <= w_dout_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rc_nxt    = r_rc;
        w_key_nxt   = r_key;
        w_blk_nxt   = r_blk;
        w_dout_nxt  = r_dout;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_reuse) begin
                        w_state_nxt = DEC;
                        w_key_nxt   = w_cache_key;
                        w_blk_nxt   = data_in ^ w_cache_key[79:16];
                        w_rc_nxt    = c_last_rc;
                    end else begin
                        w_state_nxt = KEYEXP;
                        w_key_nxt   = key;
                        w_blk_nxt   = data_in;
                        w_rc_nxt    = RC_W'(1);
                    end
                end
            end
            KEYEXP: begin
                w_key_nxt = w_key_fwd;
                w_rc_nxt  = r_rc + RC_W'(1);
                if (r_rc == c_last_rc) begin
                    // Final whitening with K32 happens on the way into DEC.
                    w_blk_nxt   = r_blk ^ w_key_fwd[79:16];
                    w_rc_nxt    = c_last_rc;
                    w_state_nxt = DEC;
                end
            end
            DEC: begin
                w_key_nxt = w_key_inv;
                w_blk_nxt = w_blk_dec;
                w_rc_nxt  = r_rc - RC_W'(1);
                if (r_rc == RC_W'(1)) begin
                    w_state_nxt = IDLE;
                    w_dout_nxt  = w_blk_dec;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign data_out = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_present_dec_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_present_dec_core
//  Description : Self-checking bench for present_dec_core against a
//                behavioural PRESENT-80 encryption model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_present_dec_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [79:0] key = '0;
    logic [63:0] data_in = '0;
`ifdef PRESENT_DEC_KEYCACHE_EN
    logic        key_reuse = 1'b0;
`endif
    logic        busy;
    logic        done;
    logic [63:0] data_out;

    int tests = 0;
    int fails = 0;

    localparam logic [79:0] KF = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

    logic [3:0] m_sbox [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    always #5 clk = ~clk;

    present_dec_core #(.ROUNDS(31)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .data_in   (data_in),
`ifdef PRESENT_DEC_KEYCACHE_EN
        .key_reuse (key_reuse),
`endif
        .busy      (busy),
        .done      (done),
        .data_out  (data_out)
    );

    // Straightforward PRESENT-80 encryption; the DUT must invert it.
    function automatic logic [63:0] m_encrypt(input logic [79:0] k0, input logic [63:0] pt);
        logic [79:0] k = k0;
        logic [63:0] s = pt;
        logic [63:0] t;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = m_sbox[s[4*n +: 4]];
            t = '0;
            for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (16 * i) % 63] = s[i];
            s = t;
            k = {k[18:0], k[79:19]};
            k[79:76] = m_sbox[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [79:0] k, input logic [63:0] ct);
        key     = k;
        data_in = ct;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Returns in the cycle where done is high (or after the cycle budget runs out).
    task automatic wait_done(output int bcyc, output int dcnt, output logic [63:0] res);
        bcyc = 0;
        dcnt = 0;
        res  = 'x;
        for (int c = 0; c < 300 && dcnt == 0; c++) begin
            if (done) begin
                dcnt = 1;
                res  = data_out;
            end else begin
                if (busy) bcyc++;
                tick();
            end
        end
    endtask

    initial begin
        int          bc, dc, extra;
        logic [63:0] res, pt, ct;
        logic [79:0] rk;
        logic [31:0] ra, rb, rc;

        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dout", data_out, 64'd0);
        rst_n = 1'b1;
        tick();

        launch('0, 64'h5579C1387B228445);
        wait_done(bc, dc, res);
        check("v1_done", 64'(dc), 64'd1);
        check("v1_data", res, 64'h0000000000000000);
        check("v1_busy_cycles", 64'(bc), 64'd62);
        tick();
        check("v1_single_done", 64'(done), 64'd0);

        launch(KF, 64'hE72C46C0F5945049);
        wait_done(bc, dc, res);
        check("v2_data", res, 64'h0000000000000000);
        tick();

        launch('0, 64'hA112FFC72F68417B);
        wait_done(bc, dc, res);
        check("v3_data", res, 64'hFFFFFFFFFFFFFFFF);
        launch(KF, 64'h3333DCD3213210D2);
        wait_done(bc, dc, res);
        check("b2b_done", 64'(dc), 64'd1);
        check("b2b_data", res, 64'hFFFFFFFFFFFFFFFF);
        check("b2b_busy_cycles", 64'(bc), 64'd62);
        tick();
        check("b2b_single_done", 64'(done), 64'd0);

        // Abort in DEC round 15 (busy cycle 46).
        launch(KF, 64'hE72C46C0F5945049);
        for (int i = 0; i < 45; i++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_dout", data_out, 64'd0);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) extra++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (done) extra++;
        end
        check("abort_no_done", 64'(extra), 64'd0);
        launch(KF, 64'h3333DCD3213210D2);
        wait_done(bc, dc, res);
        check("after_abort_data", res, 64'hFFFFFFFFFFFFFFFF);
        tick();

        // Start during busy cycle 10 with different data must be dropped.
        launch('0, 64'h5579C1387B228445);
        for (int i = 0; i < 9; i++) tick();
        key     = KF;
        data_in = 64'h0123456789ABCDEF;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done(bc, dc, res);
        check("ign_done", 64'(dc), 64'd1);
        check("ign_data", res, 64'h0000000000000000);
        check("ign_busy_cycles", 64'(bc), 64'd52);
        tick();
        check("ign_no_second_done", 64'(done), 64'd0);
        check("ign_idle_after", 64'(busy), 64'd0);

        for (int n = 0; n < 8; n++) begin
            ra = $urandom; rb = $urandom; rc = $urandom;
            rk = {ra[15:0], rb, rc};
            ra = $urandom; rb = $urandom;
            pt = {ra, rb};
            ct = m_encrypt(rk, pt);
            launch(rk, ct);
            wait_done(bc, dc, res);
            check($sformatf("rand%0d_data", n), res, pt);
            check($sformatf("rand%0d_busy", n), 64'(bc), 64'd62);
            if ((n % 2) == 0) tick();
        end
        tick();

`ifdef PRESENT_DEC_KEYCACHE_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        key_reuse = 1'b1;
        launch(KF, 64'hE72C46C0F5945049);
        wait_done(bc, dc, res);
        check("kc_cold_data", res, 64'h0000000000000000);
        check("kc_cold_busy", 64'(bc), 64'd62);
        tick();
        key_reuse = 1'b0;
        launch('0, 64'h5579C1387B228445);
        wait_done(bc, dc, res);
        check("kc_fill_data", res, 64'h0000000000000000);
        tick();
        key_reuse = 1'b1;
        ra = $urandom;
        launch({48'h0, ra}, 64'hA112FFC72F68417B);
        key_reuse = 1'b0;
        wait_done(bc, dc, res);
        check("kc_reuse_data", res, 64'hFFFFFFFFFFFFFFFF);
        check("kc_reuse_busy", 64'(bc), 64'd31);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/present_dec_core.md
PRESENT_DEC_CORE -- requirements
Module: present_dec_core

Interface
REQ-001 Parameter ROUNDS, default 31, number of PRESENT-80 rounds; only 31 is verified.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request decryption; sampled only in IDLE.
REQ-005 key  input  80  PRESENT-80 user key; sampled with start.
REQ-006 data_in  input  64  ciphertext; sampled with start.
REQ-007 key_reuse  input  1  skip key expansion using the cached final key; present only with PRESENT_DEC_KEYCACHE_EN.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 done  output  1  one-cycle pulse when data_out becomes valid.
REQ-010 data_out  output  64  plaintext, held until the next accepted start.

Function
REQ-011 The FSM SHALL have the states IDLE, KEYEXP and DEC.
REQ-012 IDLE->KEYEXP SHALL occur on start=1, latching key into key_reg (80b), data_in into state_reg (64b), and setting round counter rc=1.
REQ-013 KEYEXP SHALL, each cycle, apply the forward schedule: rotate left 61, S-box on [79:76], XOR rc into [19:15]; rc increments, for exactly 31 cycles (rc 1..31).
REQ-014 On KEYEXP exit, key_reg SHALL hold the K32 state, state_reg SHALL load state_reg ^ K32[79:16], rc SHALL be set to 31, and the FSM SHALL enter DEC.
REQ-015 DEC SHALL, each cycle, apply the inverse schedule to key_reg: XOR rc into [19:15], inverse S-box on [79:76], rotate right 61.
REQ-016 In the same DEC cycle, state_reg SHALL become invS(invP(state_reg)) ^ K'[79:16], where K' is the inverse-updated key and invS is 16 parallel nibble inverse S-boxes.
REQ-017 invP SHALL map bit 16*i mod 63 back to bit i for i<63, with bit 63 fixed.
REQ-018 DEC SHALL run 31 cycles (rc 31 down to 1); on the rc=1 cycle the FSM SHALL return to IDLE, load data_out with the new state, and assert done for that one cycle.
REQ-019 Latency SHALL be: start sampled at edge T gives done=1 in the cycle after edge T+62 (62 busy cycles).
REQ-020 start while busy SHALL be ignored, with no queueing.
REQ-021 start asserted in the same cycle as done SHALL be accepted, because the FSM is back in IDLE.
REQ-022 rc SHALL be 5 bits wide and SHALL never wrap.

Reset
REQ-023 rst_n=0 SHALL force, at any time including mid-operation, state=IDLE, rc=0, key_reg=0, state_reg=0, data_out=0, done=0 and busy=0.
REQ-024 Any aborted operation SHALL produce no done.
REQ-025 The key cache SHALL reset to 0 and its valid flag to 0.

Configuration
REQ-026 The macro PRESENT_DEC_KEYCACHE_EN SHALL control the key cache.
- Defined: a 80b K32 cache register and a valid flag are loaded at every KEYEXP exit.
- Defined: start with key_reuse=1 and valid=1 goes IDLE->DEC directly, using the cache as key_reg and data_in ^ cache[79:16] as state_reg; done arrives 31 busy cycles after start.
- Defined: key_reuse=1 with valid=0 behaves as a normal start.
- Undefined: no key_reuse port and no cache; every start runs KEYEXP.

Structure
REQ-027 Package present_pkg SHALL hold the FSM state enum, PRESENT_ROUNDS=31, the key/block width constants, and the forward S-box and invP functions.
REQ-028 The natural sub-module SHALL be present_inv_sbox_layer (64b in/out, 16 instances of the team's 4-bit inverse S-box cell).
REQ-029 The key schedule forward S-box SHALL be inline logic.

Verification
REQ-030 Key=0, ct=5579C1387B228445 -> done once, data_out=0000000000000000, 62 busy cycles.
REQ-031 Key=FFFF_FFFFFFFF_FFFFFFFF, ct=E72C46C0F5945049 -> data_out=0000000000000000.
REQ-032 Key=0, ct=A112FFC72F68417B -> data_out=FFFFFFFFFFFFFFFF; then, back-to-back in the done cycle, key=all-F, ct=3333DCD3213210D2 -> FFFFFFFFFFFFFFFF.
REQ-033 start pulsed at busy cycle 10 with other data -> ignored; first result unchanged, single done.
REQ-034 rst_n low at DEC cycle 15 -> all outputs 0 immediately, no done; new start afterwards gives a correct result.
REQ-035 (KEYCACHE_EN) key=0, decrypt once, then key_reuse=1, ct=A112FFC72F68417B -> FFFFFFFFFFFFFFFF after 31 busy cycles; key_reuse=1 straight after reset -> 62-cycle path.
